multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 52 +++++
 tb/tb_multiplier.sv | 124 ++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// multiplier: sequential unsigned 32x32 shift-add multiplier, 32 steps, registered 64-bit product
module multiplier #(
  parameter logic [5:0] MULTU = 6'b011001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [31:0] mcand;
  logic [63:0] prod;
  logic [5:0]  count;
  logic [32:0] sum;
  logic [63:0] step;
  logic        start;
  logic        last;
  assign start = (state != RUN) && (Signal == MULTU);
  assign last  = (state == RUN) && (count == 6'd31);
  // 33-bit sum keeps the carry that becomes product bit 63
  assign sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
  assign step  = {sum, prod[31:1]};
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  always_comb begin
    next = IDLE;
    next = start ? RUN : (state == RUN ? (last ? DONE : RUN) : IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand   <= '0;
      prod    <= '0;
      count   <= '0;
      dataOut <= '0;
    end else if (start) begin
      mcand <= dataA;
      prod  <= {32'd0, dataB};
      count <= '0;
    end else if (state == RUN) begin
      prod  <= step;
      count <= count + 6'd1;
      if (last) dataOut <= step;
    end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: randomized self-checking bench; reference is plain 64-bit arithmetic with fixed 32-edge latency
module tb_multiplier;
  localparam logic [5:0] MULTU = 6'b011001;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy, done;
  int          passed = 0;
  int          total = 0;
  logic [63:0] last_prod = '0;

  multiplier #(.MULTU(MULTU)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .dataOut(dataOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] noise;
    logic [5:0] s;
    s = 6'($urandom);
    return (s == MULTU) ? 6'd0 : s;
  endfunction

  // start at edge 0, result due after edge 32; restart_at injects an ignored MULTU
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int restart_at, input bit idle_after);
    logic [63:0] exp;
    exp = {32'd0, a} * {32'd0, b};
    Signal = MULTU; dataA = a; dataB = b;
    tick;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_hold", dataOut, last_prod);
    for (int k = 1; k <= 31; k++) begin
      Signal = (k == restart_at) ? MULTU : noise();
      dataA  = (k == restart_at) ? 32'd2 : $urandom;
      dataB  = (k == restart_at) ? 32'd2 : $urandom;
      tick;
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_hold", dataOut, last_prod);
    end
    Signal = noise();
    tick;
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_prod", dataOut, exp);
    last_prod = exp;
    if (idle_after) begin
      Signal = noise();
      tick;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_prod", dataOut, exp);
    end
  endtask

  initial begin
    reset = 1'b1; Signal = MULTU; dataA = 32'd1; dataB = 32'd1;
    #12;
    check("rst_prod", dataOut, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    Signal = 6'd0;
    reset = 1'b0;
    tick;
    run_op(32'd3, 32'd5, -1, 1'b1);
    run_op(32'd0, 32'h1234_5678, -1, 1'b1);
    run_op(32'd7, 32'd9, 10, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(32'h0001_0000, 32'h0001_0000, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      Signal = noise();
      tick;
      check("noise_busy", busy, 0);
      check("noise_done", done, 0);
    end
    Signal = MULTU; dataA = 32'h8000_0000; dataB = 32'd2;
    tick;
    Signal = noise();
    repeat (12) tick;
    #2 reset = 1'b1;
    #1;
    check("abort_prod", dataOut, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    Signal = MULTU;
    repeat (2) tick;
    check("held_busy", busy, 0);
    reset = 1'b0;
    Signal = noise();
    last_prod = '0;
    for (int i = 0; i < 40; i++) begin
      tick;
      check("post_abort_done", done, 0);
      check("post_abort_busy", busy, 0);
    end
    check("post_abort_prod", dataOut, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    run_op(32'hDEAD_BEEF, 32'h0000_0010, -1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (i % 7 == 0) ? 32'd0 : $urandom;
      run_op(a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1, 1'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
